// File: rtl/cache_pkg.sv
// Shared definitions for the cache arbiter: bus width defaults, FSM states, cache geometry.
package cache_pkg;

  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_DATA_W = 32;

  // Direct-mapped cache geometry: tag | index | word offset
  localparam int TAG_W    = 21;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RELEASE
  } arb_state_t;

endpackage

// File: rtl/cache_arb_pick.sv
// Winner selection between the instruction-fetch and data ports.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin; otherwise DM has fixed priority.
module cache_arb_pick
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic if_req,
  input  logic dm_req,
  output logic pick_dm
);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // Remembers which port was served last; reset value means "IF served last".
  logic last_dm_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dm_reg <= 1'b0;
    end else if (grant_en) begin
      last_dm_reg <= pick_dm;
    end
  end

  assign pick_dm = dm_req & (~if_req | ~last_dm_reg);
`else
  logic unused_rr;
  assign unused_rr = &{1'b0, clk, rst, grant_en, if_req};

  assign pick_dm = dm_req;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Two-port (IF / DM) arbiter in front of a single-ported cache with a done handshake.
// Round-robin selection is enabled by defining CACHE_ARB_ROUND_ROBIN_EN.
module cache_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_read_en,
  input  logic              dm_write_en,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              CPU_read_en,
  output logic              CPU_write_en,
  output logic [ADDR_W-1:0] CPU_addr,
  output logic [DATA_W-1:0] CPU_write_din,
  input  logic [DATA_W-1:0] CPU_read_dout,
  input  logic              cache_done,
  output logic [1:0]        grant
);

  arb_state_t state_reg, state_next;

  logic              rd_en_reg, wr_en_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg, dm_rdata_reg;
  logic              if_done_reg, dm_done_reg;
  logic [1:0]        grant_reg;

  logic              dm_req;
  logic              pick_dm;
  logic              start, finish;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;

  // Requesters are word-addressed on the cache side; byte lanes are dropped.
  logic unused_byte_bits;
  assign unused_byte_bits = &{1'b0, if_addr[1:0], dm_addr[1:0]};

  assign dm_req    = dm_read_en | dm_write_en;
  assign sel_write = pick_dm & dm_write_en;
  assign sel_addr  = pick_dm ? dm_addr : if_addr;

  cache_arb_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .grant_en (start),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .pick_dm  (pick_dm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (if_req | dm_req) begin
          start      = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cache_done) begin
          finish     = 1'b1;
          state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_reg    <= 1'b0;
      wr_en_reg    <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
      if_done_reg  <= 1'b0;
      dm_done_reg  <= 1'b0;
      grant_reg    <= 2'b00;
    end else begin
      if_done_reg <= 1'b0;
      dm_done_reg <= 1'b0;
      if (start) begin
        addr_reg  <= {sel_addr[ADDR_W-1:2], 2'b00};
        wdata_reg <= pick_dm ? dm_wdata : '0;
        rd_en_reg <= ~sel_write;
        wr_en_reg <= sel_write;
        grant_reg <= pick_dm ? 2'b10 : 2'b01;
      end
      // grant_reg still names the owner on the completing edge
      if (finish) begin
        rd_en_reg <= 1'b0;
        wr_en_reg <= 1'b0;
        grant_reg <= 2'b00;
        if (grant_reg[1]) begin
          dm_done_reg <= 1'b1;
          if (rd_en_reg) dm_rdata_reg <= CPU_read_dout;
        end else begin
          if_done_reg <= 1'b1;
          if (rd_en_reg) if_rdata_reg <= CPU_read_dout;
        end
      end
    end
  end

  assign CPU_read_en   = rd_en_reg;
  assign CPU_write_en  = wr_en_reg;
  assign CPU_addr      = addr_reg;
  assign CPU_write_din = wdata_reg;
  assign if_rdata      = if_rdata_reg;
  assign dm_rdata      = dm_rdata_reg;
  assign if_done       = if_done_reg;
  assign dm_done       = dm_done_reg;
  assign grant         = grant_reg;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with a fixed-latency word-addressed cache model.
module tb_cache_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          dm_read_en, dm_write_en;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          dm_done;
  logic          CPU_read_en, CPU_write_en;
  logic [AW-1:0] CPU_addr;
  logic [DW-1:0] CPU_write_din, CPU_read_dout;
  logic          cache_done;
  logic [1:0]    grant;

  int passed = 0;
  int total  = 0;

  // Observations from the last transaction
  logic          obs_to, obs_ifd, obs_dmd, obs_en_done, obs_done_after, obs_stable;
  logic          obs_re, obs_we;
  logic [1:0]    obs_g;
  logic [AW-1:0] obs_a;
  logic [DW-1:0] obs_w;
  int            obs_cyc;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_read_en(dm_read_en), .dm_write_en(dm_write_en), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .CPU_read_en(CPU_read_en), .CPU_write_en(CPU_write_en), .CPU_addr(CPU_addr),
    .CPU_write_din(CPU_write_din), .CPU_read_dout(CPU_read_dout),
    .cache_done(cache_done), .grant(grant)
  );

  // Cache model: done pulse LAT cycles after an enable is first seen
  logic [DW-1:0] mem [0:1023];
  int            lat_cnt;

  always @(posedge clk) begin
    if (rst) begin
      cache_done    <= 1'b0;
      lat_cnt       <= 0;
      CPU_read_dout <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      cache_done <= 1'b0;
      if ((CPU_read_en || CPU_write_en) && !cache_done) begin
        if (lat_cnt == LAT - 1) begin
          lat_cnt    <= 0;
          cache_done <= 1'b1;
          if (CPU_write_en) mem[CPU_addr[11:2]] <= CPU_write_din;
          else              CPU_read_dout <= mem[CPU_addr[11:2]];
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  // Drive requests from an IDLE-cycle negedge and wait for a done pulse
  task automatic xact(input logic ifr, input logic dmr, input logic dmw,
                      input logic [AW-1:0] ia, input logic [AW-1:0] da,
                      input logic [DW-1:0] wd, input logic drop_early);
    if_req = ifr; if_addr = ia;
    dm_read_en = dmr; dm_write_en = dmw; dm_addr = da; dm_wdata = wd;
    obs_to = 1'b1; obs_ifd = 1'b0; obs_dmd = 1'b0; obs_en_done = 1'b0;
    obs_stable = 1'b1; obs_cyc = 0; obs_g = 2'b00; obs_a = '0; obs_w = '0;
    obs_re = 1'b0; obs_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      obs_cyc++;
      if (obs_cyc == 1) begin
        obs_g = grant; obs_a = CPU_addr; obs_w = CPU_write_din;
        obs_re = CPU_read_en; obs_we = CPU_write_en;
        if (drop_early) begin if_req = 1'b0; dm_read_en = 1'b0; dm_write_en = 1'b0; end
      end else if ((CPU_read_en || CPU_write_en) && (CPU_addr !== obs_a || CPU_write_din !== obs_w)) begin
        obs_stable = 1'b0;
      end
      if (if_done || dm_done) begin
        obs_ifd = if_done; obs_dmd = dm_done;
        obs_en_done = CPU_read_en | CPU_write_en;
        obs_to = 1'b0;
        break;
      end
    end
    if (obs_ifd) if_req = 1'b0;
    if (obs_dmd) begin dm_read_en = 1'b0; dm_write_en = 1'b0; end
    if (obs_to) begin if_req = 1'b0; dm_read_en = 1'b0; dm_write_en = 1'b0; end
    @(negedge clk);
    obs_done_after = if_done | dm_done;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b0; dm_read_en = 1'b0; dm_write_en = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    total++; if ({CPU_read_en, CPU_write_en, if_done, dm_done, grant} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000", {CPU_read_en, CPU_write_en, if_done, dm_done, grant}); else passed++;
    total++; if ({CPU_addr, CPU_write_din} !== '0)
      $display("FAIL reset_cpu_bus: got addr %h din %h expected 0", CPU_addr, CPU_write_din); else passed++;
    total++; if ({if_rdata, dm_rdata} !== '0)
      $display("FAIL reset_rdata: got if %h dm %h expected 0", if_rdata, dm_rdata); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dm_write;
    xact(1'b0, 1'b0, 1'b1, '0, 32'h9EC, 32'd103, 1'b0);
    total++; if (obs_to !== 1'b0) $display("FAIL dmw_timeout: no done within bound"); else passed++;
    total++; if (obs_g !== 2'b10) $display("FAIL dmw_grant: got %b expected 10", obs_g); else passed++;
    total++; if ({obs_re, obs_we} !== 2'b01) $display("FAIL dmw_enables: got %b expected 01", {obs_re, obs_we}); else passed++;
    total++; if (obs_a !== 32'h9EC) $display("FAIL dmw_addr: got %h expected 000009ec", obs_a); else passed++;
    total++; if (obs_w !== 32'd103) $display("FAIL dmw_din: got %0d expected 103", obs_w); else passed++;
    total++; if (obs_stable !== 1'b1) $display("FAIL dmw_stable: got %b expected 1", obs_stable); else passed++;
    total++; if ({obs_ifd, obs_dmd} !== 2'b01) $display("FAIL dmw_done: got %b expected 01", {obs_ifd, obs_dmd}); else passed++;
    total++; if (obs_cyc !== LAT + 2) $display("FAIL dmw_latency: got %0d expected %0d", obs_cyc, LAT + 2); else passed++;
    total++; if (obs_done_after !== 1'b0) $display("FAIL dmw_pulse_width: got %b expected 0", obs_done_after); else passed++;
    total++; if ({if_rdata, dm_rdata} !== '0) $display("FAIL dmw_rdata_hold: got if %h dm %h expected 0", if_rdata, dm_rdata); else passed++;
  endtask

  task automatic test_if_read;
    xact(1'b1, 1'b0, 1'b0, 32'h9EF, '0, '0, 1'b0);
    total++; if (obs_to !== 1'b0) $display("FAIL ifr_timeout: no done within bound"); else passed++;
    total++; if (obs_g !== 2'b01) $display("FAIL ifr_grant: got %b expected 01", obs_g); else passed++;
    total++; if ({obs_re, obs_we} !== 2'b10) $display("FAIL ifr_enables: got %b expected 10", {obs_re, obs_we}); else passed++;
    total++; if (obs_a !== 32'h9EC) $display("FAIL ifr_addr: got %h expected 000009ec", obs_a); else passed++;
    total++; if ({obs_ifd, obs_dmd} !== 2'b10) $display("FAIL ifr_done: got %b expected 10", {obs_ifd, obs_dmd}); else passed++;
    total++; if (obs_en_done !== 1'b0) $display("FAIL ifr_release_en: got %b expected 0", obs_en_done); else passed++;
    total++; if (if_rdata !== 32'd103) $display("FAIL ifr_rdata: got %0d expected 103", if_rdata); else passed++;
    total++; if (dm_rdata !== 32'd0) $display("FAIL ifr_dm_hold: got %0d expected 0", dm_rdata); else passed++;
    total++; if (obs_done_after !== 1'b0) $display("FAIL ifr_pulse_width: got %b expected 0", obs_done_after); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_g;
    for (int i = 0; i < 4; i++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b10;
`endif
      xact(1'b1, 1'b1, 1'b0, 32'h9EC, 32'h9EC, '0, 1'b0);
      total++; if (obs_g !== exp_g) $display("FAIL b2b_grant%0d: got %b expected %b", i, obs_g, exp_g); else passed++;
      total++; if ({obs_dmd, obs_ifd} !== exp_g) $display("FAIL b2b_done%0d: got %b expected %b", i, {obs_dmd, obs_ifd}, exp_g); else passed++;
    end
    if_req = 1'b0; dm_read_en = 1'b0;
    @(negedge clk);
    total++; if (dm_rdata !== 32'd103) $display("FAIL b2b_dm_rdata: got %0d expected 103", dm_rdata); else passed++;
  endtask

  task automatic test_drop;
    xact(1'b1, 1'b0, 1'b0, 32'h9EC, '0, '0, 1'b1);
    total++; if ({obs_to, obs_ifd} !== 2'b01) $display("FAIL drop_done: got to/done %b expected 01", {obs_to, obs_ifd}); else passed++;
  endtask

  task automatic test_reset_busy;
    logic saw_done;
    saw_done = 1'b0;
    dm_write_en = 1'b1; dm_addr = 32'h100; dm_wdata = 32'd55;
    @(negedge clk);
    total++; if (CPU_write_en !== 1'b1) $display("FAIL rstb_busy: got we %b expected 1", CPU_write_en); else passed++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({CPU_read_en, CPU_write_en, grant} !== 4'b0) $display("FAIL rstb_async: got %b expected 0000", {CPU_read_en, CPU_write_en, grant}); else passed++;
    dm_write_en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (if_done || dm_done) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (if_done || dm_done) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) $display("FAIL rstb_no_done: got %b expected 0", saw_done); else passed++;
    xact(1'b0, 1'b1, 1'b0, '0, 32'h100, '0, 1'b0);
    total++; if ({obs_to, obs_g, obs_dmd} !== 4'b0101) $display("FAIL rstb_restart: got to/grant/done %b expected 0101", {obs_to, obs_g, obs_dmd}); else passed++;
    total++; if (obs_cyc !== LAT + 2) $display("FAIL rstb_latency: got %0d expected %0d", obs_cyc, LAT + 2); else passed++;
    total++; if (dm_rdata !== 32'd0) $display("FAIL rstb_aborted_write: got %0d expected 0", dm_rdata); else passed++;
  endtask

  task automatic test_rw_both;
    xact(1'b0, 1'b1, 1'b1, '0, 32'hA80, 32'd200, 1'b0);
    total++; if ({obs_re, obs_we} !== 2'b01) $display("FAIL rw_is_write: got %b expected 01", {obs_re, obs_we}); else passed++;
    total++; if (obs_w !== 32'd200) $display("FAIL rw_din: got %0d expected 200", obs_w); else passed++;
    total++; if (obs_dmd !== 1'b1) $display("FAIL rw_done: got %b expected 1", obs_dmd); else passed++;
    xact(1'b0, 1'b1, 1'b0, '0, 32'hA83, '0, 1'b0);
    total++; if (obs_a !== 32'hA80) $display("FAIL rw_read_addr: got %h expected 00000a80", obs_a); else passed++;
    total++; if (dm_rdata !== 32'd200) $display("FAIL rw_readback: got %0d expected 200", dm_rdata); else passed++;
    total++; if (if_rdata !== 32'd0) $display("FAIL rw_if_hold: got %0d expected 0", if_rdata); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_dm_write;
    test_if_read;
    test_back_to_back;
    test_drop;
    test_reset_busy;
    test_rw_both;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, width of all data ports.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-006 SHALL have port if_addr  input  ADDR_W  instruction byte address.
REQ-007 SHALL have port if_rdata  output  DATA_W  instruction read data.
REQ-008 SHALL have port if_done  output  1  one-cycle completion pulse for the instruction-fetch port.
REQ-009 SHALL have port dm_read_en / dm_write_en  input  1 each  data-port read / write request.
REQ-010 SHALL have ports dm_addr  input  ADDR_W; dm_wdata  input  DATA_W; dm_rdata  output  DATA_W; dm_done  output  1  one-cycle completion pulse for the data port.
REQ-011 SHALL have cache-side ports CPU_read_en, CPU_write_en  output  1; CPU_addr  output  ADDR_W; CPU_write_din  output  DATA_W; CPU_read_dout  input  DATA_W; cache_done  input  1.
REQ-012 SHALL have port grant  output  2  one-hot owner of the cache (bit0 IF, bit1 DM), 0 when idle.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> RELEASE -> IDLE.
REQ-014 IDLE: on any pending request, SHALL select a winner, latch its address, write data and operation, and enter BUSY at the next edge.
REQ-015 BUSY: SHALL drive CPU_read_en or CPU_write_en from registers, holding address and data stable until cache_done=1.
REQ-016 On the edge sampling cache_done=1 in BUSY, SHALL deassert the CPU enables, register CPU_read_dout into the winner's rdata (reads only), pulse the winner's done for exactly one cycle, and enter RELEASE.
REQ-017 RELEASE SHALL last one cycle with enables low, so the cache sees enable low before any new request, then SHALL return to IDLE.
REQ-018 Minimum latency SHALL be cache latency + 2 cycles; no new grant SHALL be issued sooner than 1 cycle after a done pulse.
REQ-019 CPU_addr[1:0] SHALL be forced to 2'b00; requester address bits [1:0] SHALL be ignored.
REQ-020 If dm_read_en and dm_write_en are both 1, the request SHALL be treated as a write.
REQ-021 A requester dropping its request while in BUSY SHALL NOT abort the access; the done pulse SHALL still be issued.
REQ-022 if_rdata and dm_rdata SHALL hold their last value until the next completed read on that port.
REQ-023 Requesters SHALL hold their request until done; a request still high in the cycle after done SHALL be treated as a new request.

Reset
REQ-024 On rst=1, SHALL immediately enter IDLE and force CPU_read_en=0, CPU_write_en=0, CPU_addr=0, CPU_write_din=0, if_rdata=0, dm_rdata=0, if_done=0, dm_done=0, grant=0; the RR pointer SHALL be set to IF.
REQ-025 Reset during BUSY SHALL abandon the access with no done pulse.

Configuration
REQ-026 With macro CACHE_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port not served last, with the pointer updated at each grant.
REQ-027 With CACHE_ARB_ROUND_ROBIN_EN undefined, the DM port SHALL always win simultaneous requests (fixed priority), and no pointer register SHALL exist.

Structure
REQ-028 Shared package cache_pkg SHALL hold ADDR_W/DATA_W defaults, the FSM state typedef, and cache geometry constants: TAG_W=21, INDEX_W=6, OFFSET_W=3.
REQ-029 Winner selection SHALL be one sub-module, cache_arb_pick: combinational pick plus the optional RR pointer.

Verification
REQ-030 DM write dm_addr=0x9EC (tag 1, index 15, offset 3), dm_wdata=103 -> CPU_write_en high with CPU_addr=0x9EC and CPU_write_din=103 until cache_done; dm_done pulses 1 cycle; grant=2'b10.
REQ-031 IF read if_addr=0x9EF after REQ-030 -> CPU_addr=0x9EC, if_rdata=103, if_done 1 cycle, enables low for the RELEASE cycle.
REQ-032 if_req and dm_read_en asserted on the same edge, repeated 4 times -> with the macro, grants alternate DM, IF, DM, IF; without it, DM wins every time.
REQ-033 rst pulsed 2 cycles into BUSY -> enables drop asynchronously, no done pulse, grant=0, and the next request restarts cleanly.
REQ-034 dm_read_en and dm_write_en both high, dm_addr=0xA80 (index 20), dm_wdata=200 -> write performed; a later read of 0xA80 returns 200.
